// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: sequences the PC, reads the synchronous imem, slices the word into decode fields.
// Latency: REQ -> dec_valid in 2 cycles; one instruction per 3 cycles with dec_ready held high.
// Backpressure: fields are held in HOLD until dec_ready; no new fetch is issued while an instruction is presented.
module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd4,
    parameter logic [2:0]  HALT_OPCODE = 3'b111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [2:0]  opcode,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  shamt,
    output logic [3:0]  fcode,
    output logic [21:0] imm,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } state_t;

    // Decoded view of one instruction word; imm deliberately overlaps rt/shamt.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  shamt;
        logic [3:0]  fcode;
        logic [21:0] imm;
    } dec_t;

    state_t      state;
    logic [31:0] pc;
    dec_t        dec_q;
    dec_t        dec_d;
    logic [31:0] pc_inc;
    logic [31:0] accept_pc;
    logic        is_halt;

    assign pc_inc    = pc + PC_STEP;
    // A redirect coinciding with the handshake steers the fetch after the accepted instruction.
    assign accept_pc = redirect_valid ? redirect_pc : pc_inc;
    assign is_halt   = (dec_q.opcode == HALT_OPCODE);

    // Fixed field slicing, independent of opcode.
    always_comb begin
        dec_d         = '0;
        dec_d.opcode  = imem_rdata[31:29];
        dec_d.rs_addr = imem_rdata[28:24];
        dec_d.rt_addr = imem_rdata[23:19];
        dec_d.shamt   = imem_rdata[18:14];
        dec_d.fcode   = imem_rdata[3:0];
        dec_d.imm     = imem_rdata[21:0];
    end

    assign opcode  = dec_q.opcode;
    assign rs_addr = dec_q.rs_addr;
    assign rt_addr = dec_q.rt_addr;
    assign shamt   = dec_q.shamt;
    assign fcode   = dec_q.fcode;
    assign imm     = dec_q.imm;

    // Fetch sequencer with registered outputs; redirect beats the normal transition except against an accepted halt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_rd_en <= 1'b0;
            imem_addr  <= RESET_PC;
            dec_valid  <= 1'b0;
            dec_pc     <= '0;
            dec_q      <= '0;
            halted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state      <= REQ;
                        imem_rd_en <= 1'b1;
                        imem_addr  <= pc;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        // Re-issue at the target; the read just issued is abandoned.
                        state      <= REQ;
                        pc         <= redirect_pc;
                        imem_rd_en <= 1'b1;
                        imem_addr  <= redirect_pc;
                    end else begin
                        state      <= WAIT;
                        imem_rd_en <= 1'b0;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        // Returning word is dropped without touching the field registers.
                        state      <= REQ;
                        pc         <= redirect_pc;
                        imem_rd_en <= 1'b1;
                        imem_addr  <= redirect_pc;
                    end else begin
                        state     <= HOLD;
                        dec_q     <= dec_d;
                        dec_pc    <= pc;
                        dec_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (dec_ready) begin
                        dec_valid <= 1'b0;
                        if (is_halt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state      <= REQ;
                            pc         <= accept_pc;
                            imem_rd_en <= 1'b1;
                            imem_addr  <= accept_pc;
                        end
                    end else if (redirect_valid) begin
                        // Presented instruction is squashed, never accepted.
                        state      <= REQ;
                        dec_valid  <= 1'b0;
                        pc         <= redirect_pc;
                        imem_rd_en <= 1'b1;
                        imem_addr  <= redirect_pc;
                    end
                end
                HALT: begin
                    imem_rd_en <= 1'b0;
                    dec_valid  <= 1'b0;
                    halted     <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    imem_rd_en <= 1'b0;
                    dec_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: random and directed stimulus, transaction-level model and scoreboard.
// Latency: model expects dec_valid 2 cycles after each fetch strobe.
// Backpressure: dec_ready is driven randomly and held low for stretches.
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [2:0]  opcode;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  shamt;
    logic [3:0]  fcode;
    logic [21:0] imm;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch_decode dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .opcode(opcode), .rs_addr(rs_addr), .rt_addr(rt_addr), .shamt(shamt),
        .fcode(fcode), .imm(imm), .halted(halted)
    );

    // Synchronous instruction memory, 256 words, address wraps on bits [9:2].
    logic [31:0] mem [0:255];
    always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr[9:2]];

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t q[$];
    exp_t e;

    function automatic exp_t mk(input logic [31:0] p);
        exp_t r;
        r.pc   = p;
        r.word = mem[p[9:2]];
        return r;
    endfunction

    function automatic logic [75:0] fields_of(input exp_t x);
        return {x.pc, x.word[31:29], x.word[28:24], x.word[23:19], x.word[18:14], x.word[3:0], x.word[21:0]};
    endfunction

    // Model state: the instruction the front end owes next, plus one-shot expectations for the following cycle.
    bit          started = 0;
    bit          mhalted = 0;
    bit          after_hs = 0;
    bit          hs_halt = 0;
    bit          after_redir = 0;
    bit          prev_valid = 0;
    logic [31:0] redir_target = '0;
    int          cyc = 0;
    int          last_req = 0;

    // Monitor: compare on the falling edge, then advance the model for the coming rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            q.delete();
            started     = 0;
            mhalted     = 0;
            after_hs    = 0;
            after_redir = 0;
            prev_valid  = 0;
            check("reset_outputs",
                  {imem_rd_en, dec_valid, halted, imem_addr, dec_pc, opcode, rs_addr, rt_addr, shamt, fcode, imm},
                  {3'b000, 32'h0, 76'h0});
        end else begin
            if (after_hs) begin
                if (hs_halt) check("halt_rise", {halted, imem_rd_en, dec_valid}, 3'b100);
                else check("next_fetch", {imem_rd_en, dec_valid, imem_addr}, {1'b1, 1'b0, q[0].pc});
            end
            if (after_redir)
                check("redirect_fetch", {imem_rd_en, dec_valid, imem_addr}, {1'b1, 1'b0, redir_target});
            after_hs    = 0;
            after_redir = 0;

            if (!started || mhalted) begin
                check("quiet", {imem_rd_en, dec_valid, halted}, {2'b00, mhalted});
            end else begin
                if (imem_rd_en) begin
                    check("fetch_addr", {imem_addr, dec_valid, halted}, {q[0].pc, 2'b00});
                    last_req = cyc;
                end
                if (dec_valid) begin
                    check("dec_fields",
                          {dec_pc, opcode, rs_addr, rt_addr, shamt, fcode, imm, imem_rd_en, halted},
                          {fields_of(q[0]), 2'b00});
                    if (!prev_valid) check("latency", cyc - last_req, 2);
                end
                if (!imem_rd_en && !dec_valid) check("no_halt_yet", halted, 1'b0);
            end
            prev_valid = dec_valid;

            if (!started) begin
                if (en) begin
                    started = 1;
                    q.push_back(mk(32'h0));
                end
            end else if (!mhalted) begin
                if (dec_valid && dec_ready) begin
                    e = q.pop_front();
                    after_hs = 1;
                    if (e.word[31:29] == 3'b111) begin
                        hs_halt = 1;
                        mhalted = 1;
                    end else begin
                        hs_halt = 0;
                        q.push_back(mk(redirect_valid ? redirect_pc : e.pc + 32'd4));
                    end
                end else if (redirect_valid) begin
                    q.delete();
                    q.push_back(mk(redirect_pc));
                    after_redir  = 1;
                    redir_target = redirect_pc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic start();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_valid_pc(input logic [31:0] p, input string nm);
        int n = 0;
        while (!(dec_valid && dec_pc == p) && n < 200) begin
            tick();
            n++;
        end
        check(nm, n < 200, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {3'($urandom_range(0, 6)), 29'($urandom)};
        mem[0]  = 32'h0000_0001;
        mem[1]  = 32'h2345_6789;
        mem[64] = 32'hE000_0000;

        // Straight-line fetch with dec_ready high.
        do_reset();
        dec_ready = 1'b1;
        start();
        repeat (12) tick();

        // Hold the first instruction for 5 extra cycles.
        do_reset();
        dec_ready = 1'b0;
        start();
        wait_valid_pc(32'h0, "wait_first");
        repeat (5) tick();
        dec_ready = 1'b1;
        repeat (6) tick();

        // Redirect while the read is in flight.
        do_reset();
        dec_ready = 1'b1;
        start();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        wait_valid_pc(32'h40, "wait_redirect_40");
        repeat (4) tick();

        // Redirect together with the handshake at PC 8, landing on a halt word.
        do_reset();
        dec_ready = 1'b1;
        start();
        wait_valid_pc(32'h8, "wait_pc8");
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        begin
            int n = 0;
            while (!halted && n < 50) begin
                tick();
                n++;
            end
            check("wait_halted", n < 50, 1'b1);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        repeat (5) tick();
        do_reset();
        repeat (4) tick();

        // Asynchronous reset while an instruction is presented.
        do_reset();
        dec_ready = 1'b0;
        start();
        wait_valid_pc(32'h0, "wait_hold");
        #2 rst = 1'b0;
        #1 check("async_reset", {dec_valid, imem_rd_en, imem_addr}, 34'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Randomized traffic: backpressure, redirects anywhere, stray en pulses.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            start();
            for (int c = 0; c < 150; c++) begin
                dec_ready      = ($urandom_range(0, 9) < 7);
                redirect_valid = ($urandom_range(0, 9) == 0);
                redirect_pc    = $urandom & 32'hFFFF_FFFC;
                en             = $urandom_range(0, 1);
                tick();
            end
            redirect_valid = 1'b0;
            en = 1'b0;
            repeat (3) tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
